// File: rtl/fpu_mantissa_mul_seq_pkg.sv
// Shared FPU_192 definitions: mantissa/product widths, multiplier FSM states
// and the normalized multiply result bundle.
package FPU_192_Package;

  localparam int NORMALIZE_MANTISSA_LENGTH = 24;
  localparam int MUL_PRODUCT_LENGTH        = 2 * NORMALIZE_MANTISSA_LENGTH;
  localparam int MUL_CNT_LENGTH            = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] prod_mant;
    logic                                 guard;
    logic                                 round;
    logic                                 sticky;
    logic                                 exp_adj;
  } mul_result_t;

endpackage

// File: rtl/fpu_mantissa_mul_seq_normalize.sv
// Combinational normalization of a raw 2*MANT_W-bit mantissa product into
// the 1.x result mantissa plus guard/round/sticky and exponent adjust.
module fpu_mul_normalize
  import FPU_192_Package::*;
#(
  parameter int MANT_W = NORMALIZE_MANTISSA_LENGTH
) (
  input  logic [2*MANT_W-1:0] prod,
  output mul_result_t         res
);

  always_comb begin
    res = '0;
    // Raw product of two 1.x values lies in [1,4); bit 2W-1 set means >= 2.0
    if (prod[2*MANT_W-1]) begin
      res.prod_mant = prod[2*MANT_W-1 -: MANT_W];
      res.guard     = prod[MANT_W-1];
      res.round     = prod[MANT_W-2];
      res.sticky    = |prod[MANT_W-3:0];
      res.exp_adj   = 1'b1;
    end else begin
      res.prod_mant = prod[2*MANT_W-2 -: MANT_W];
      res.guard     = prod[MANT_W-2];
      res.round     = prod[MANT_W-3];
      res.sticky    = |prod[MANT_W-4:0];
      res.exp_adj   = 1'b0;
    end
  end

endmodule

// File: rtl/fpu_mantissa_mul_seq.sv
// Iterative MSB-first radix-2 mantissa multiplier with valid/ready handshakes.
// Optional macro FPU_MUL_EARLY_TERM_EN skips iterations over trailing zero multiplier bits.
module fpu_mantissa_mul_seq
  import FPU_192_Package::*;
#(
  parameter int MANT_W = NORMALIZE_MANTISSA_LENGTH,
  parameter int CNT_W  = MUL_CNT_LENGTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] prod_mant,
  output logic              guard_bit,
  output logic              round_bit,
  output logic              sticky_bit,
  output logic              exp_adj
);

  mul_state_e          state;
  logic [MANT_W-1:0]   a_q;
  logic [MANT_W-1:0]   b_q;
  logic [2*MANT_W-1:0] acc;
  logic [2*MANT_W-1:0] acc_step;
  logic [CNT_W-1:0]    cnt;
  mul_result_t         norm_res;

  assign acc_step = (acc << 1) + {{MANT_W{1'b0}}, (b_q[cnt] ? a_q : '0)};

`ifdef FPU_MUL_EARLY_TERM_EN
  logic [MANT_W-1:0] low_mask;
  logic              lower_zero;

  // Bits of b below the current position; empty (all clear) when cnt==0
  assign low_mask   = (MANT_W'(1) << cnt) - MANT_W'(1);
  assign lower_zero = ((b_q & low_mask) == '0);
`endif

  fpu_mul_normalize #(.MANT_W(MANT_W)) u_norm (
    .prod (acc),
    .res  (norm_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      prod_mant  <= '0;
      guard_bit  <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
      exp_adj    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= mant_a;
            b_q      <= mant_b;
            acc      <= '0;
            cnt      <= CNT_W'(MANT_W - 1);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
`ifdef FPU_MUL_EARLY_TERM_EN
          // Remaining partial products are zero: apply all pending shifts at once
          if (lower_zero) begin
            acc   <= acc_step << cnt;
            state <= NORM;
          end else begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
          end
`else
          acc <= acc_step;
          if (cnt == '0) begin
            state <= NORM;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end
        NORM: begin
          prod_mant  <= norm_res.prod_mant;
          guard_bit  <= norm_res.guard;
          round_bit  <= norm_res.round;
          sticky_bit <= norm_res.sticky;
          exp_adj    <= norm_res.exp_adj;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mantissa_mul_seq.sv
// Randomized self-checking bench for fpu_mantissa_mul_seq against an
// arithmetic product/normalization model.
module tb_fpu_mantissa_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] mant_a = '0;
  logic [23:0] mant_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] prod_mant;
  logic        guard_bit, round_bit, sticky_bit, exp_adj;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_mantissa_mul_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mant_a     (mant_a),
    .mant_b     (mant_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .prod_mant  (prod_mant),
    .guard_bit  (guard_bit),
    .round_bit  (round_bit),
    .sticky_bit (sticky_bit),
    .exp_adj    (exp_adj)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // {prod_mant, guard, round, sticky, exp_adj} from the exact product
  function automatic logic [27:0] ref_result(input logic [23:0] a, input logic [23:0] b);
    longint unsigned p, pa, pb, mant, g, r, s, adj;
    pa = a;
    pb = b;
    p  = pa * pb;
    if (p >= (64'd1 << 47)) begin
      mant = p / (64'd1 << 24);
      g    = (p / (64'd1 << 23)) % 2;
      r    = (p / (64'd1 << 22)) % 2;
      s    = ((p % (64'd1 << 22)) != 0) ? 1 : 0;
      adj  = 1;
    end else begin
      mant = p / (64'd1 << 23);
      g    = (p / (64'd1 << 22)) % 2;
      r    = (p / (64'd1 << 21)) % 2;
      s    = ((p % (64'd1 << 21)) != 0) ? 1 : 0;
      adj  = 0;
    end
    return {mant[23:0], g[0], r[0], s[0], adj[0]};
  endfunction

  function automatic int ref_latency(input logic [23:0] b);
`ifdef FPU_MUL_EARLY_TERM_EN
    int tz;
    if (b == 0) return 2;
    tz = 0;
    while (((b >> tz) & 24'd1) == 0) tz++;
    return 24 - tz + 1;
`else
    return 25;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq(tag, seen, 1'b0);
  endtask

  // Issue one operation, check latency/result, hold in DONE, then release or flush
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input int hold,
                        input bit flush_in_done);
    int lat;
    logic [27:0] exp;
    wait_ready();
    mant_a = a;
    mant_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mant_a = $urandom;
    mant_b = $urandom;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    check_eq("latency", lat, ref_latency(b));
    if (!out_valid) return;
    exp = ref_result(a, b);
    check_eq("result", {prod_mant, guard_bit, round_bit, sticky_bit, exp_adj}, exp);
    check_eq("in_ready_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_stable", {out_valid, in_ready, prod_mant, guard_bit, round_bit,
                               sticky_bit, exp_adj}, {1'b1, 1'b0, exp});
    end
    if (flush_in_done) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_eq("flush_done", {out_valid, in_ready}, 2'b01);
    end else begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("release", {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra, rb;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", {in_ready, out_valid, prod_mant, guard_bit, round_bit,
                             sticky_bit, exp_adj}, {1'b1, 1'b0, 28'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(24'h800000, 24'h800000, 0, 1'b0);
    run_op(24'hC00000, 24'hC00000, 0, 1'b0);
    run_op(24'hFFFFFF, 24'hFFFFFF, 10, 1'b0);
    run_op(24'hA00000, 24'h800000, 0, 1'b0);
    run_op(24'h000000, 24'hC35001, 0, 1'b0);
    run_op(24'hC35001, 24'h000000, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 != 5) begin
        ra[23] = 1'b1;
        rb[23] = 1'b1;
      end
      if (i % 4 == 1) rb = rb & (24'hFFFFFF << $urandom_range(0, 22));
      run_op(ra, rb, $urandom_range(0, 3), 1'b0);
    end

    // Result left in output registers so the reset check below is meaningful
    run_op(24'hC00000, 24'hC00000, 2, 1'b1);

    // Flush mid-CALC
    wait_ready();
    mant_a = 24'h800000;
    mant_b = 24'hFFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_calc", {out_valid, in_ready}, 2'b01);
    watch_no_valid("flush_no_result", 40);
    run_op(24'hA00000, 24'h800000, 0, 1'b0);

    // Flush together with in_valid in IDLE: operands dropped
    mant_a = 24'hFFFFFF;
    mant_b = 24'hFFFFFF;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check_eq("flush_idle_not_accepted", in_ready, 1'b1);
    watch_no_valid("flush_idle_no_result", 40);

    // Asynchronous reset mid-CALC
    run_op(24'hC00000, 24'hC00000, 0, 1'b0);
    mant_a = 24'hFFFFFF;
    mant_b = 24'hFFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_calc", {in_ready, out_valid, prod_mant, guard_bit, round_bit,
                                sticky_bit, exp_adj}, {1'b1, 1'b0, 28'h0});
    #5;
    rst_n = 1'b1;
    watch_no_valid("reset_no_result", 40);
    run_op(24'h800000, 24'hFFFFFF, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_mantissa_mul_seq.md
Name: fpu_mantissa_mul_seq

Overview:
- Iterative radix-2 mantissa multiplier for the DD192 FPU multiply path. It is the inverse operation of the restoring mantissa divider.
- Takes two normalized 24-bit mantissas (hidden bit at MSB) and returns a normalized 24-bit product. Also returns guard, round and sticky bits and a 1-bit exponent adjust.
- Sits between the FPU operand unpack stage and the shared rounding/exponent stage, using valid/ready handshakes on both sides.

Parameters:
- MANT_W, default NORMALIZE_MANTISSA_LENGTH (24): mantissa width including the hidden bit.
- CNT_W, default 5: iteration counter width. Must satisfy 2^CNT_W >= MANT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- mant_a  in  MANT_W  multiplicand mantissa.
- mant_b  in  MANT_W  multiplier mantissa.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- prod_mant  out  MANT_W  normalized product mantissa.
- guard_bit  out  1  first bit below the product LSB.
- round_bit  out  1  second bit below the product LSB.
- sticky_bit  out  1  OR of all remaining lower bits.
- exp_adj  out  1  1 when the raw product is >= 2.0, meaning the exponent needs +1.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0; prod_mant, guard_bit, round_bit, sticky_bit, exp_adj=0; accumulator, operand registers and counter = 0.
- FSM states: IDLE, CALC, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch mant_a and mant_b, clear the 2*MANT_W accumulator, set cnt=MANT_W-1, go to CALC.
- CALC (in_ready=0), one iteration per clock, MSB-first:
  - acc <= (acc<<1) + (b[cnt] ? a : 0).
  - When cnt==0, go to NORM; otherwise cnt decrements.
- NORM:
  - Raw product P = acc (2*MANT_W = 48 bits).
  - If P[47]=1: prod_mant=P[47:24], guard=P[23], round=P[22], sticky=|P[21:0], exp_adj=1.
  - Otherwise: prod_mant=P[46:23], guard=P[22], round=P[21], sticky=|P[20:0], exp_adj=0.
  - Load the output registers and go to DONE.
- DONE:
  - out_valid=1. Outputs are held stable until out_ready.
  - On out_valid&&out_ready: out_valid drops on the next edge and the state returns to IDLE.
  - in_ready stays 0 throughout DONE; there is no overlap of the next accept with the current result.
- Latency (macro off): out_valid is high after exactly MANT_W+1 = 25 rising edges following the accept edge. Throughput is one operation per MANT_W+3 cycles when out_ready is held at 1.
- Zero/denormal operands: there is no special-casing. The arithmetic is exact for any inputs; a zero product gives all outputs 0 and exp_adj=0.
- flush:
  - Has priority over all transitions in every state.
  - Next state is IDLE and out_valid=0.
  - Output data registers hold their values; they are don't-care while out_valid=0.
- Simultaneous flush with in_valid in IDLE: flush wins and the operands are not accepted.
- Reset asserted mid-operation: immediate return to reset values. No partial result is ever presented.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: FPU_MUL_EARLY_TERM_EN.
- With the macro defined, a CALC edge checks whether the remaining lower multiplier bits b[cnt-1:0] are all zero (always true when cnt==0). If so:
  - acc <= ((acc<<1) + pp) << cnt, in one step using a barrel shift.
  - Go to NORM.
- Resulting latency = (MANT_W - trailing_zeros(mant_b)) + 1. For mant_b=0, latency is 2.
- Results are bit-identical to the macro-off build.
- Without the macro, latency is fixed at MANT_W+1 and the barrel shifter is not instantiated.

Decomposition:
- Shared package (FPU_192_Package) gets:
  - MUL_PRODUCT_LENGTH = 2*NORMALIZE_MANTISSA_LENGTH.
  - MUL_CNT_LENGTH = 5.
  - A typedef enum for the FSM states (IDLE/CALC/NORM/DONE).
  - A packed struct typedef for the result bundle {prod_mant, guard, round, sticky, exp_adj}.
- One natural sub-module, fpu_mul_normalize: the combinational NORM mapping from the 48-bit product to the result struct. It is reusable by a future array multiplier.

Test Plan:
- Reset check: assert rst_n=0 mid-CALC. Outputs go to reset values immediately, in_ready=1, out_valid=0, and no result ever appears.
- mant_a=mant_b=0x800000 (1.0×1.0): prod_mant=0x800000, G/R/S=0/0/0, exp_adj=0. out_valid after 25 edges (2 with FPU_MUL_EARLY_TERM_EN).
- mant_a=mant_b=0xC00000 (1.5×1.5), raw product 0x900000000000: prod_mant=0x900000, G/R/S=0/0/0, exp_adj=1.
- mant_a=mant_b=0xFFFFFF, raw product 0xFFFFFE000001: prod_mant=0xFFFFFE, guard=0, round=0, sticky=1, exp_adj=1. Latency 25 with or without the macro.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs stay stable and in_ready=0; release out_ready and the next operand pair is accepted on the following IDLE cycle.
- Flush: pulse flush 5 cycles after accepting 0x800000×0xFFFFFF. Block returns to IDLE and out_valid never rises; a new pair 0xA00000×0x800000 then yields prod_mant=0xA00000, exp_adj=0.
